// File: rtl/rv32_inst_encoder_pkg.sv
// rv32_inst_encoder_pkg: shared formats, opcodes and immediate limits for the RV32I encoder
package rv32_inst_encoder_pkg;
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -1048576;
    localparam int IMMJ_MAX  = 1048574;
endpackage

// File: rtl/rv32_inst_encoder_pack.sv
// rv32_inst_pack: combinational field packing and immediate legality check
module rv32_inst_pack
    import rv32_inst_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);
    fmt_e               f;
    logic signed [31:0] s;
    logic               r12, rb, rj;

    assign f   = fmt_e'(fmt);
    assign s   = imm;
    assign r12 = s >= IMM12_MIN && s <= IMM12_MAX;
    assign rb  = s >= IMMB_MIN && s <= IMMB_MAX && !imm[0];
    assign rj  = s >= IMMJ_MIN && s <= IMMJ_MAX && !imm[0];

    always_comb begin
        legal = f == FMT_R ? 1'b1 :
                (f == FMT_I || f == FMT_S) ? r12 :
                f == FMT_B ? rb :
                f == FMT_J ? rj :
                f == FMT_U ? imm[11:0] == 12'd0 : 1'b0;
        word  = f == FMT_R ? {funct7, rs2, rs1, funct3, rd, opcode} :
                f == FMT_I ? {imm[11:0], rs1, funct3, rd, opcode} :
                f == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                f == FMT_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
                f == FMT_U ? {imm[31:12], rd, opcode} :
                f == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} : 32'd0;
    end
endmodule

// File: rtl/rv32_inst_encoder.sv
// rv32_inst_encoder: packs instruction fields into words streamed out with auto-incrementing addresses
module rv32_inst_encoder
    import rv32_inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              imm_err,
    output logic [7:0]        err_count
);
    logic [31:0]       word;
    logic              legal, acc;
    logic [ADDR_W-1:0] addr_cnt, base;

    rv32_inst_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .word   (word),
        .legal  (legal)
    );

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;
    // a same-cycle load overrides the counter for the word being accepted
    assign base     = addr_load ? addr_in : addr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= 32'd0;
            out_addr  <= '0;
            addr_cnt  <= '0;
            imm_err   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            imm_err <= acc && !legal;
            if (acc && !legal && err_count != 8'hff)
                err_count <= err_count + 8'd1;
            if (acc && legal) begin
                out_valid <= 1'b1;
                out_word  <= word;
                out_addr  <= base;
                addr_cnt  <= base + 1'b1;
            end else begin
                if (out_ready)
                    out_valid <= 1'b0;
                if (addr_load)
                    addr_cnt <= addr_in;
            end
        end
    end
endmodule

// File: tb/tb_rv32_inst_encoder.sv
// tb_rv32_inst_encoder: table-driven scoreboard bench for the RV32I instruction encoder
module tb_rv32_inst_encoder;
    localparam int AW = 8;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [2:0]    fmt = '0, funct3 = '0;
    logic [6:0]    opcode = '0, funct7 = '0;
    logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]   imm = '0;
    logic          addr_load = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic          out_valid, out_ready = 1'b1;
    logic [31:0]   out_word;
    logic [AW-1:0] out_addr;
    logic          imm_err;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    rv32_inst_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .addr_load(addr_load), .addr_in(addr_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .imm_err(imm_err), .err_count(err_count)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        bit          legal;
    } vec_t;

    typedef struct {
        logic [31:0]   word;
        logic [AW-1:0] addr;
    } exp_t;

    vec_t          tv[20];
    exp_t          q[$];
    int            errors = 0, checks = 0, exp_err = 0;
    logic [AW-1:0] exp_addr = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h at %h expected none", out_word, out_addr);
            end else begin
                e = q.pop_front();
                chk("out_word", out_word, e.word);
                chk("out_addr", 32'(out_addr), 32'(e.addr));
            end
        end
    end

    task automatic drive(vec_t v, bit ld = 1'b0, logic [AW-1:0] la = '0);
        int n = 0;
        fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
        addr_load = ld; addr_in = la; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        if (v.legal) begin
            q.push_back('{v.word, ld ? la : exp_addr});
            exp_addr = (ld ? la : exp_addr) + 1'b1;
        end else begin
            if (ld) exp_addr = la;
            if (exp_err < 255) exp_err++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        addr_load = 1'b0;
        chk("imm_err", 32'(imm_err), 32'(!v.legal));
        chk("err_count", 32'(err_count), 32'(exp_err));
    endtask

    initial begin
        tv[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,          32'h00500093, 1'b1};
        tv[1]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,          32'h0020A423, 1'b1};
        tv[2]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd4,        32'hFE000EE3, 1'b1};
        tv[3]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h001000EF, 1'b1};
        tv[4]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,   32'h123452B7, 1'b1};
        tv[5]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h0,        1'b0};
        tv[6]  = '{3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'hDEADBEEF,   32'h003100B3, 1'b1};
        tv[7]  = '{3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h0,          32'h403100B3, 1'b1};
        tv[8]  = '{3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'h00, -32'sd2048,     32'h80018113, 1'b1};
        tv[9]  = '{3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,       32'h7FF00013, 1'b1};
        tv[10] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, -32'sd2049,     32'h0,        1'b0};
        tv[11] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,       32'h7E000FE3, 1'b1};
        tv[12] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,       32'h0,        1'b0};
        tv[13] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,          32'h0,        1'b0};
        tv[14] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd1048576,  32'h8000006F, 1'b1};
        tv[15] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048576,    32'h0,        1'b0};
        tv[16] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800,   32'h0,        1'b0};
        tv[17] = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,          32'h0,        1'b0};
        tv[18] = '{3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,          32'h0,        1'b0};
        tv[19] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048574,    32'h7FFFF06F, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_imm_err", 32'(imm_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tv[i]);
            if (i == 5) chk("reject_drops_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        drive(tv[0]);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_word", out_word, 32'h00500093);
        end
        out_ready = 1'b1;

        drive(tv[1], 1'b1, 8'd255);
        drive(tv[9]);

        for (int i = 0; i < 300; i++) drive(tv[17]);
        chk("err_saturated", 32'(err_count), 32'd255);
        drive(tv[0]);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        drive(tv[4]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        exp_addr = '0;
        exp_err = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(tv[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv32_inst_encoder.md
# rv32_inst_encoder

Instruction encoder for the RV32I test-program loader: accepts decoded instruction fields plus a full-width immediate, range-checks the immediate for the selected format, and packs them into a 32-bit instruction word. Each good word is emitted with an auto-incrementing instruction-memory word address through a valid/ready output stage. It is the write-side inverse of the datapath's immediate generator. Words it produces must decode back to the same immediate and fields.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept this cycle
- fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 illegal
- opcode  in  7  placed in IR[6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  placed in IR[14:12]
- funct7  in  7  placed in IR[31:25] (R only)
- imm  in  32  signed byte-offset or value (U: full 32-bit value)
- addr_load  in  1  load address counter from addr_in
- addr_in  in  ADDR_W  load value
- out_valid  out  1  out_word/out_addr valid
- out_ready  in  1  memory side accepts
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_word
- imm_err  out  1  one-cycle pulse on rejected input
- err_count  out  8  saturating reject count

## Operation
- Accept: in_valid && in_ready.
- Field packing:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Unused fields for a format are ignored.
- Legality checks (signed imm):
  - I/S: −2048..2047.
  - B: −4096..4094, imm[0]=0.
  - J: −1048576..1048574, imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored.
  - fmt 6/7: always illegal.
- Illegal accept:
  - Word dropped; no output; counter unchanged.
  - imm_err pulses next cycle.
  - err_count increments, saturating at 255.
- Legal accept:
  - Output register loads word and current counter value.
  - Counter advances by 1, wrapping 2^ADDR_W−1 → 0.
- addr_load:
  - Counter ← addr_in.
  - If simultaneous with a legal accept, that word uses addr_in and the counter becomes addr_in+1.
- Reset values: out_valid=0, out_word=0, out_addr=0, counter=0, imm_err=0, err_count=0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- in_ready = !out_valid || out_ready, combinational, no input-to-input path beyond this.
- Full throughput: one word per cycle while out_ready=1.
- Output stability: out_word/out_addr stay stable while out_valid && !out_ready.
- out_valid clears after a handshake unless a new legal word is accepted in the same cycle.
- Illegal accept with the output stalled cannot occur, because in_ready=0.
- Illegal accept while the output drains: out_valid falls; imm_err pulses.
- rst_n asserted mid-stream:
  - All state clears immediately.
  - The pending word is lost.
  - in_ready=1 after deassertion.

## Structure
- Shared defines file:
  - Opcode constants.
  - fmt encodings FMT_R…FMT_J.
  - Immediate range limits.
- Sub-module rv32_inst_pack: combinational fields → word plus legal flag.
- Top level holds the output register, address counter, and error counter.

## Test plan
- addi: fmt=I, opcode=0x13, rd=1, rs1=0, f3=0, imm=5 → out_word=0x00500093, out_addr=0.
- sw, then back-to-back: fmt=S, opcode=0x23, rs1=1, rs2=2, f3=2, imm=8 → 0x0020A423 at addr 1.
- beq and jal, back-to-back:
  - beq: fmt=B, opcode=0x63, rs1=rs2=0, imm=−4 → 0xFE000EE3.
  - jal: fmt=J, opcode=0x6F, rd=1, imm=2048 → 0x001000EF.
  - Consecutive addresses; one word per cycle.
- lui with reject:
  - lui: fmt=U, opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7.
  - fmt=I with imm=2048 → no out_valid; imm_err pulse; err_count=1; address unchanged.
- Backpressure and wrap:
  - out_ready=0 for 3 cycles → out_word held, in_ready=0.
  - addr_load addr_in=255, then two words (ADDR_W=8) → addresses 255, 0.
  - 300 illegal inputs → err_count=255.
